pmem_line_responder: RTL and testbench

Synthesizable responder for the 32-byte-line physical-memory interface driven by the non-blocking data cache (`pmem_read`/`pmem_write`/`pmem_address`/`pmem_wdata`, answered by `pmem_resp`/`pmem_rdata`). It accepts one line read or line write at a time and holds a small line store with per-line valid bits. It answers after a programmable latency with a one-cycle `pmem_resp`. It is the memory-side end of the cache's miss/writeback path: it is used as the L2 stand-in for integration and as the stimulus target for cache verification, and it flags requester protocol violations.

---
 rtl/lc3b_types.sv | 20 ++
 rtl/pmem_line_array.sv | 40 ++++
 rtl/pmem_line_responder.sv | 133 +++++++++++++
 tb/tb_pmem_line_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line typedefs and the responder FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_32bytes;

  // Exposed here so cache benches can probe the responder state by name.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_resp_state_t;

  function automatic int pmem_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line store: LINES x 256-bit data with per-line valid bits; invalid lines read as zero.
// Latency: combinational read, write visible the cycle after we_i.
// Backpressure: none; one write per cycle, data is never cleared, only valid bits on reset.
// Ports: clk/reset, write port (we_i, widx_i, wdata_i), read port (ridx_i -> rdata_o).
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int LINES = 16,
  localparam int IW = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  lc3b_32bytes   wdata_i,
  input  logic [IW-1:0] ridx_i,
  output lc3b_32bytes   rdata_o
);

  lc3b_32bytes      mem_q [LINES];
  logic [LINES-1:0] valid_q;

  // Data is deliberately left uninitialised across reset; validity gates it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  assign rdata_o = valid_q[ridx_i] ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory line responder: one line read/write at a time after a fixed latency.
// Latency: READ_LATENCY / WRITE_LATENCY cycles from acceptance to the one-cycle pmem_resp.
// Backpressure: requester holds pmem_read/pmem_write until pmem_resp; changes mid-flight set protocol_error.
// Ports: clk/reset, request (pmem_read, pmem_write, pmem_address, pmem_wdata),
//        response (pmem_resp, pmem_rdata), sticky protocol_error.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int LINES         = 16,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_32bytes pmem_wdata,
  output logic        pmem_resp,
  output lc3b_32bytes pmem_rdata,
  output logic        protocol_error
);

  localparam int IW   = $clog2(LINES);
  localparam int MAXL = pmem_max(READ_LATENCY, WRITE_LATENCY);
  localparam int CW   = $clog2(MAXL + 1);

  pmem_resp_state_t state_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_q;
  logic [IW-1:0]    idx_q;
  logic [10:0]      tag_q;
  lc3b_32bytes      wdata_q;
  lc3b_32bytes      rdata_q;
  logic             resp_q;
  logic             perr_q;

  logic [IW-1:0] req_idx;
  logic [CW-1:0] lat_m1;
  logic [IW-1:0] arr_ridx;
  lc3b_32bytes   arr_rdata;
  logic          arr_we;
  logic          req_changed;

  assign req_idx = pmem_address[5 +: IW];
  // Write wins when both request lines are high, so it also picks the latency.
  assign lat_m1  = pmem_write ? CW'(WRITE_LATENCY - 1) : CW'(READ_LATENCY - 1);

  // A latency of 1 enters RESP straight from IDLE, before idx_q is loaded.
  assign arr_ridx = (state_q == IDLE) ? req_idx : idx_q;

  // Commit on the edge leaving RESP; a coincident reset abandons the write.
  assign arr_we = (state_q == RESP) && wr_q && !reset;

  assign req_changed = (wr_q ? !pmem_write : !pmem_read) || (pmem_address[15:5] != tag_q);

  pmem_line_array #(
    .LINES(LINES)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we_i   (arr_we),
    .widx_i (idx_q),
    .wdata_i(wdata_q),
    .ridx_i (arr_ridx),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (pmem_write || pmem_read) begin
            wr_q    <= pmem_write;
            idx_q   <= req_idx;
            tag_q   <= pmem_address[15:5];
            wdata_q <= pmem_wdata;
            cnt_q   <= lat_m1;
            if (pmem_write && pmem_read) begin
              perr_q <= 1'b1;
            end
            if (lat_m1 == '0) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              if (!pmem_write) begin
                rdata_q <= arr_rdata;
              end
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (req_changed) begin
            perr_q <= 1'b1;
          end
          if (cnt_q == CW'(1)) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            if (!wr_q) begin
              rdata_q <= arr_rdata;
            end
          end
        end
        RESP: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pmem_resp      = resp_q;
  assign pmem_rdata     = rdata_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: transaction-level model of the line store and response timing,
// compared against the DUT outputs every cycle, plus literal expectations from the test plan.
// Uses distinct read/write latencies so a swapped latency is visible.
module tb_pmem_line_responder;

  localparam int LINES = 16;
  localparam int RL    = 8;
  localparam int WL    = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         protocol_error;

  pmem_line_responder #(
    .LINES        (LINES),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: line contents/validity plus what each output must be this cycle.
  logic [255:0] m_data  [LINES];
  bit           m_valid [LINES];
  logic         exp_resp;
  logic [255:0] exp_rdata;
  logic         exp_perr;
  bit           perr_pend;
  bit           checking;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_resp", {255'b0, pmem_resp}, {255'b0, exp_resp});
      chk("cyc_rdata", pmem_rdata, exp_rdata);
      chk("cyc_perr", {255'b0, protocol_error}, {255'b0, exp_perr});
    end
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int line_of(input logic [15:0] a);
    return int'(a[15:5]) % LINES;
  endfunction

  // Advance to the next cycle; errors flagged last cycle become visible now.
  task automatic tick();
    @(posedge clk);
    #1;
    if (perr_pend) exp_perr = 1'b1;
    perr_pend = 1'b0;
    exp_resp  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'($urandom);
      pmem_wdata   = rand_line();
    end
  endtask

  // One transaction starting in the next cycle; returns in its RESP cycle with inputs still held.
  // mut_kind: 0 none, 1 change address[15:5], 2 drop the op line; applied in BUSY cycle mut_at.
  task automatic run_txn(input bit wr, input bit rd, input logic [15:0] addr,
                         input logic [255:0] data, input int mut_kind, input int mut_at);
    int         lat;
    int         idx;
    logic [10:0] hi;
    lat = wr ? WL : RL;
    idx = line_of(addr);
    hi  = addr[15:5];
    tick();
    pmem_write   = wr;
    pmem_read    = rd;
    pmem_address = addr;
    pmem_wdata   = data;
    if (wr && rd) perr_pend = 1'b1;
    for (int k = 1; k < lat; k++) begin
      tick();
      // Offset bits and write data may wander without being a violation.
      pmem_address = {hi, 5'($urandom)};
      pmem_wdata   = rand_line();
      if (mut_kind != 0 && k == mut_at) begin
        if (mut_kind == 1) begin
          hi = hi ^ 11'($urandom_range(1, 2047));
          pmem_address = {hi, pmem_address[4:0]};
        end else if (wr) begin
          pmem_write = 1'b0;
        end else begin
          pmem_read = 1'b0;
        end
        perr_pend = 1'b1;
      end
    end
    tick();
    exp_resp = 1'b1;
    if (!wr) exp_rdata = m_valid[idx] ? m_data[idx] : 256'h0;
    if (wr) begin
      m_data[idx]  = data;
      m_valid[idx] = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_rdata = '0;
    exp_perr  = 1'b0;
    perr_pend = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset      = 1'b1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    bit wr, rd;
    int mk;
    checking     = 1'b0;
    reset        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    exp_resp     = 1'b0;
    perr_pend    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1'b1;
    chk("reset_resp", {255'b0, pmem_resp}, 256'h0);
    chk("reset_rdata", pmem_rdata, 256'h0);
    chk("reset_perr", {255'b0, protocol_error}, 256'h0);

    // Invalid line read: response exactly RL cycles after the request, data zero.
    run_txn(1'b0, 1'b1, 16'h0040, '0, 0, 0);
    chk("inv_read_resp", {255'b0, pmem_resp}, 256'h1);
    chk("inv_read_rdata", pmem_rdata, 256'h0);
    chk("inv_read_perr", {255'b0, protocol_error}, 256'h0);
    idle(1);

    // Write then read the same line through a different byte offset.
    run_txn(1'b1, 1'b0, 16'h0060, {8{32'hDEADBEEF}}, 0, 0);
    idle(1);
    run_txn(1'b0, 1'b1, 16'h007F, '0, 0, 0);
    chk("wr_rd_rdata", pmem_rdata, {8{32'hDEADBEEF}});
    idle(1);

    // 0x0200 and 0x0000 both land on line 0 with 16 lines.
    run_txn(1'b1, 1'b0, 16'h0200, {8{32'h12345678}}, 0, 0);
    idle(1);
    run_txn(1'b0, 1'b1, 16'h0000, '0, 0, 0);
    chk("alias_rdata", pmem_rdata, {8{32'h12345678}});
    idle(2);

    // Clean randomized traffic, including back-to-back transactions.
    for (int t = 0; t < 40; t++) begin
      wr = $urandom_range(0, 1);
      run_txn(wr, !wr, 16'($urandom), rand_line(), 0, 0);
      idle($urandom_range(0, 2));
    end
    chk("rand_perr_clear", {255'b0, protocol_error}, 256'h0);

    // Reset during a write's BUSY phase: nothing commits, no response, outputs reset.
    tick();
    pmem_write   = 1'b1;
    pmem_read    = 1'b0;
    pmem_address = 16'h0020;
    pmem_wdata   = {8{32'hCAFEF00D}};
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    pmem_write = 1'b0;
    model_reset();
    chk("rst_busy_resp", {255'b0, pmem_resp}, 256'h0);
    chk("rst_busy_rdata", pmem_rdata, 256'h0);
    chk("rst_busy_perr", {255'b0, protocol_error}, 256'h0);
    idle(WL + 2);
    run_txn(1'b0, 1'b1, 16'h0020, '0, 0, 0);
    chk("rst_busy_read", pmem_rdata, 256'h0);
    idle(1);

    // Address changed mid-read: error sticks, response still carries the original line.
    run_txn(1'b1, 1'b0, 16'h0040, {8{32'h0BADF00D}}, 0, 0);
    idle(1);
    tick();
    pmem_read    = 1'b1;
    pmem_write   = 1'b0;
    pmem_address = 16'h0040;
    tick();
    tick();
    pmem_address = 16'h0080;
    perr_pend    = 1'b1;
    for (int k = 3; k < RL; k++) tick();
    tick();
    exp_resp  = 1'b1;
    exp_rdata = m_data[line_of(16'h0040)];
    chk("chg_rdata", pmem_rdata, {8{32'h0BADF00D}});
    chk("chg_perr", {255'b0, protocol_error}, 256'h1);
    idle(3);
    chk("chg_perr_sticky", {255'b0, protocol_error}, 256'h1);

    // Both lines high: write wins, error set; held request restarts right after RESP.
    do_reset();
    d = rand_line();
    run_txn(1'b1, 1'b1, 16'h0100, d, 0, 0);
    run_txn(1'b1, 1'b1, 16'h0100, d, 0, 0);
    chk("both_resp2", {255'b0, pmem_resp}, 256'h1);
    chk("both_perr", {255'b0, protocol_error}, 256'h1);
    idle(1);
    run_txn(1'b0, 1'b1, 16'h0100, '0, 0, 0);
    chk("both_rdata", pmem_rdata, d);
    idle(1);

    // Randomized traffic with violations mixed in.
    do_reset();
    for (int t = 0; t < 20; t++) begin
      wr = $urandom_range(0, 1);
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      mk = $urandom_range(0, 2);
      run_txn(wr, rd, 16'($urandom), rand_line(), mk,
              $urandom_range(1, (wr ? WL : RL) - 1));
      idle($urandom_range(0, 2));
    end

    idle(2);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
